vjtag_gpio_regs: RTL and testbench

//  Register-slave stage directly downstream of vjtag_host: consumes its address/write/read bus and

---
 rtl/vjtag_gpio_pkg.sv | 20 ++
 rtl/vjtag_sync2.sv | 38 +++
 rtl/vjtag_gpio_regs.sv | 174 +++++++++++++++++
 tb/tb_vjtag_gpio_regs.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vjtag_gpio_pkg.sv
// -----------------------------------------------------------------------------
// vjtag_gpio_pkg
//   Shared constants for the vjtag_gpio_regs register slave: the word
//   addresses of every register in the map and the default ID value.
//   Addresses are kept 16 bits wide and cast to the slave's address width
//   at the point of comparison.
// -----------------------------------------------------------------------------
package vjtag_gpio_pkg;

  localparam logic [15:0] REG_ID     = 16'd0;
  localparam logic [15:0] REG_SCRATCH = 16'd1;
  localparam logic [15:0] REG_LED    = 16'd2;
  localparam logic [15:0] REG_SW     = 16'd3;
  localparam logic [15:0] REG_SW_CHG = 16'd4;
  localparam logic [15:0] REG_CNT_LO = 16'd5;
  localparam logic [15:0] REG_CNT_HI = 16'd6;

  localparam logic [15:0] ID_DEFAULT = 16'hA5C3;

endpackage

// File: rtl/vjtag_sync2.sv
// -----------------------------------------------------------------------------
// vjtag_sync2
//   Parameterized-width two-flop synchronizer for bringing asynchronous pins
//   (board switches) into the clk domain. Each bit is synchronized on its
//   own; multi-bit coherence is not guaranteed, which is acceptable for
//   independent switches.
// Ports
//   clk  in  1  system clock
//   rst  in  1  synchronous active-high reset, clears both stages
//   d    in  W  asynchronous input
//   q    out W  synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module vjtag_sync2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // The first stage may go metastable; only the second stage is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vjtag_gpio_regs.sv
// -----------------------------------------------------------------------------
// vjtag_gpio_regs
//   Register slave sitting behind vjtag_host. Decodes the host's simple
//   address/write/read bus and returns registered read data. Holds the LED
//   output register, synchronized switch inputs, a sticky switch-change
//   register (write-1-to-clear), a scratch register and a read-only ID.
//
//   Register map (word addresses, full-width compare):
//     0 ID (RO)  1 SCRATCH (RW)  2 LED (RW)  3 SW (RO)  4 SW_CHG (RW1C)
//     5 CNT_LO   6 CNT_HI   (only with VJTAG_GPIO_CNT_EN, else unmapped)
//
//   Optional feature macro: VJTAG_GPIO_CNT_EN adds a 32-bit free-running
//   cycle counter. Reading CNT_LO snapshots the upper half so a following
//   CNT_HI read is coherent with it.
//
// Ports
//   clk       in   1       system clock
//   rst       in   1       synchronous active-high reset
//   soft_rst  in   1       synchronous soft reset (registers, not sync/counter)
//   address   in   AW      register word address
//   wvalid    in   1       write request
//   wdata     in   DW      write data
//   wready    out  1       write accept (always 1)
//   rvalid    in   1       read request
//   rready    out  1       read accept (low while a response is pending)
//   rrvalid   out  1       one-cycle read response strobe
//   rdata     out  DW      read response data, held until the next response
//   sw_in     in   GPIO_W  asynchronous switch pins
//   led_out   out  GPIO_W  LED register
// -----------------------------------------------------------------------------
module vjtag_gpio_regs
  import vjtag_gpio_pkg::*;
#(
  parameter int                AW       = 16,
  parameter int                DW       = 16,
  parameter int                GPIO_W   = 16,
  parameter logic [DW-1:0]     ID_VALUE = DW'(ID_DEFAULT),
  parameter logic [GPIO_W-1:0] LED_RST  = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic [AW-1:0]     address,
  input  logic              wvalid,
  input  logic [DW-1:0]     wdata,
  output logic              wready,
  input  logic              rvalid,
  output logic              rready,
  output logic              rrvalid,
  output logic [DW-1:0]     rdata,
  input  logic [GPIO_W-1:0] sw_in,
  output logic [GPIO_W-1:0] led_out
);

  logic [GPIO_W-1:0] led_q,     led_d;
  logic [DW-1:0]     scratch_q, scratch_d;
  logic [GPIO_W-1:0] swChg_q,   swChg_d;
  logic [GPIO_W-1:0] swD_q;
  logic              rdPend_q,  rdPend_d;
  logic              rrvalid_q;
  logic [DW-1:0]     rdata_q;
  logic [DW-1:0]     rdMux;
  logic [GPIO_W-1:0] swS;
  logic              rdAcc;
  logic              wrScratch, wrLed, wrChg;

`ifdef VJTAG_GPIO_CNT_EN
  logic [31:0]       cnt_q;
  logic [31-DW:0]    cntHi_q;
`endif

  vjtag_sync2 #(.W(GPIO_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (swS)
  );

  assign wready  = 1'b1;
  assign rready  = ~rdPend_q;
  assign rdAcc   = rvalid & ~rdPend_q;
  assign rrvalid = rrvalid_q;
  assign rdata   = rdata_q;
  assign led_out = led_q;

  // Write decode and next-state for the writable registers. Change capture
  // is applied after the W1C mask so a fresh edge always survives a clear.
  always_comb begin
    wrScratch = wvalid && (address == AW'(REG_SCRATCH));
    wrLed     = wvalid && (address == AW'(REG_LED));
    wrChg     = wvalid && (address == AW'(REG_SW_CHG));

    led_d     = wrLed     ? wdata[GPIO_W-1:0] : led_q;
    scratch_d = wrScratch ? wdata             : scratch_q;
    swChg_d   = swChg_q;
    if (wrChg) begin
      swChg_d = swChg_q & ~wdata[GPIO_W-1:0];
    end
    swChg_d   = swChg_d | (swS ^ swD_q);

    rdPend_d  = rdAcc;
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rdMux = '0;
    case (address)
      AW'(REG_ID):      rdMux = ID_VALUE;
      AW'(REG_SCRATCH): rdMux = scratch_q;
      AW'(REG_LED):     rdMux = DW'(led_q);
      AW'(REG_SW):      rdMux = DW'(swS);
      AW'(REG_SW_CHG):  rdMux = DW'(swChg_q);
`ifdef VJTAG_GPIO_CNT_EN
      AW'(REG_CNT_LO):  rdMux = cnt_q[DW-1:0];
      AW'(REG_CNT_HI):  rdMux = DW'(cntHi_q);
`endif
      default:          rdMux = '0;
    endcase
  end

  // Register state cleared by both resets; a reset also drops any pending
  // read response.
  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      led_q     <= LED_RST;
      scratch_q <= '0;
      swChg_q   <= '0;
      rdPend_q  <= 1'b0;
      rrvalid_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      scratch_q <= scratch_d;
      swChg_q   <= swChg_d;
      rdPend_q  <= rdPend_d;
      rrvalid_q <= rdPend_d;
    end
  end

  // Delayed copy of the synchronized switches for edge detection; belongs
  // to the synchronizer chain, so only the hard reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      swD_q <= '0;
    end else begin
      swD_q <= swS;
    end
  end

  // Response data is captured only on an accepted read and otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rdAcc && !soft_rst) begin
      rdata_q <= rdMux;
    end
  end

`ifdef VJTAG_GPIO_CNT_EN
  // Free-running counter; reading CNT_LO snapshots the upper half so the
  // subsequent CNT_HI read belongs to the same 32-bit value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      cntHi_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (rdAcc && (address == AW'(REG_CNT_LO))) begin
        cntHi_q <= cnt_q[31:DW];
      end
    end
  end
`endif

endmodule

// File: tb/tb_vjtag_gpio_regs.sv
// -----------------------------------------------------------------------------
// tb_vjtag_gpio_regs
//   Directed self-checking bench for vjtag_gpio_regs. Inputs change and
//   outputs are sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_vjtag_gpio_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        soft_rst;
  logic [15:0] address;
  logic        wvalid;
  logic [15:0] wdata;
  logic        wready;
  logic        rvalid;
  logic        rready;
  logic        rrvalid;
  logic [15:0] rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;

  int passCount  = 0;
  int checkCount = 0;

  vjtag_gpio_regs dut (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .address  (address),
    .wvalid   (wvalid),
    .wdata    (wdata),
    .wready   (wready),
    .rvalid   (rvalid),
    .rready   (rready),
    .rrvalid  (rrvalid),
    .rdata    (rdata),
    .sw_in    (sw_in),
    .led_out  (led_out)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drive one bus operation: a single-cycle write.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data);
    address = addr;
    wdata   = data;
    wvalid  = 1'b1;
    tick();
    wvalid  = 1'b0;
  endtask

  // Single read: waits (bounded) for rready, then expects the response
  // strobe in the following cycle.
  task automatic readReg(input string tag, input logic [15:0] addr,
                         output logic [15:0] data);
    address = addr;
    for (int n = 0; n < 8 && !rready; n++) tick();
    checkOutput({tag, "_rready"}, {31'd0, rready}, 32'd1);
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    checkOutput({tag, "_rrvalid"}, {31'd0, rrvalid}, 32'd1);
    data = rdata;
  endtask

  logic [15:0] rd;
  int          pulses;

  initial begin
    rst      = 1'b1;
    soft_rst = 1'b0;
    address  = '0;
    wvalid   = 1'b0;
    wdata    = '0;
    rvalid   = 1'b0;
    sw_in    = '0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_led", {16'd0, led_out}, 32'h0000FFFF);
    checkOutput("rst_rrvalid", {31'd0, rrvalid}, 32'd0);
    checkOutput("rst_rdata", {16'd0, rdata}, 32'd0);
    checkOutput("rst_wready", {31'd0, wready}, 32'd1);

    // ID read with one-cycle strobe and held data
    readReg("id", 16'd0, rd);
    checkOutput("id_data", {16'd0, rd}, 32'h0000A5C3);
    checkOutput("id_rready_low", {31'd0, rready}, 32'd0);
    tick();
    checkOutput("id_strobe_end", {31'd0, rrvalid}, 32'd0);
    checkOutput("id_data_held", {16'd0, rdata}, 32'h0000A5C3);

    // LED and SCRATCH write/readback
    applyStimulus(16'd2, 16'h1234);
    checkOutput("led_out", {16'd0, led_out}, 32'h00001234);
    readReg("led", 16'd2, rd);
    checkOutput("led_data", {16'd0, rd}, 32'h00001234);
    applyStimulus(16'd1, 16'hBEEF);
    readReg("scr", 16'd1, rd);
    checkOutput("scr_data", {16'd0, rd}, 32'h0000BEEF);

    // Switch synchronization and change capture
    sw_in = 16'h0005;
    repeat (4) tick();
    readReg("sw", 16'd3, rd);
    checkOutput("sw_data", {16'd0, rd}, 32'h00000005);
    readReg("chg", 16'd4, rd);
    checkOutput("chg_data", {16'd0, rd}, 32'h00000005);
    applyStimulus(16'd4, 16'h0001);
    readReg("chg_w1c", 16'd4, rd);
    checkOutput("chg_w1c_data", {16'd0, rd}, 32'h00000004);

    // Bit0 edge reaches the change logic in the same cycle as its W1C
    sw_in = 16'h0004;
    tick();
    tick();
    applyStimulus(16'd4, 16'h0001);
    readReg("chg_setwin", 16'd4, rd);
    checkOutput("chg_setwin_data", {16'd0, rd}, 32'h00000005);

    // Unmapped and read-only targets
    applyStimulus(16'd7, 16'hFFFF);
    applyStimulus(16'd0, 16'h0000);
    readReg("unm", 16'd7, rd);
    checkOutput("unm_data", {16'd0, rd}, 32'h00000000);
    readReg("ro_id", 16'd0, rd);
    checkOutput("ro_id_data", {16'd0, rd}, 32'h0000A5C3);
    readReg("scr_keep", 16'd1, rd);
    checkOutput("scr_keep_data", {16'd0, rd}, 32'h0000BEEF);
    checkOutput("led_keep", {16'd0, led_out}, 32'h00001234);

    // rvalid held four cycles: accepts every other cycle
    tick();
    address = 16'd0;
    rvalid  = 1'b1;
    pulses  = 0;
    checkOutput("hold_rready0", {31'd0, rready}, 32'd1);
    pulses += int'(rrvalid);
    tick();
    checkOutput("hold_rready1", {31'd0, rready}, 32'd0);
    pulses += int'(rrvalid);
    tick();
    checkOutput("hold_rready2", {31'd0, rready}, 32'd1);
    pulses += int'(rrvalid);
    tick();
    checkOutput("hold_rready3", {31'd0, rready}, 32'd0);
    pulses += int'(rrvalid);
    rvalid = 1'b0;
    tick();
    pulses += int'(rrvalid);
    checkOutput("hold_pulses", pulses, 32'd2);

    // Same-cycle read and write of SCRATCH returns the old value
    address = 16'd1;
    wdata   = 16'h5555;
    wvalid  = 1'b1;
    rvalid  = 1'b1;
    tick();
    wvalid  = 1'b0;
    rvalid  = 1'b0;
    checkOutput("rw_rrvalid", {31'd0, rrvalid}, 32'd1);
    checkOutput("rw_old", {16'd0, rdata}, 32'h0000BEEF);
    readReg("rw_new", 16'd1, rd);
    checkOutput("rw_new_data", {16'd0, rd}, 32'h00005555);

    // Soft reset clears registers but not the switch synchronizer
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    checkOutput("soft_led", {16'd0, led_out}, 32'h0000FFFF);
    checkOutput("soft_rrvalid", {31'd0, rrvalid}, 32'd0);
    readReg("soft_scr", 16'd1, rd);
    checkOutput("soft_scr_data", {16'd0, rd}, 32'h00000000);
    readReg("soft_chg", 16'd4, rd);
    checkOutput("soft_chg_data", {16'd0, rd}, 32'h00000000);
    readReg("soft_sw", 16'd3, rd);
    checkOutput("soft_sw_data", {16'd0, rd}, 32'h00000004);

`ifdef VJTAG_GPIO_CNT_EN
    // Coherent 32-bit counter reads across a low-half wrap
    begin
      logic [15:0] lo1, hi1, lo2, hi2;
      logic [31:0] delta;
      readReg("cnt_lo1", 16'd5, lo1);
      readReg("cnt_hi1", 16'd6, hi1);
      repeat (65540) tick();
      readReg("cnt_lo2", 16'd5, lo2);
      readReg("cnt_hi2", 16'd6, hi2);
      delta = {hi2, lo2} - {hi1, lo1};
      checkOutput("cnt_mono", {31'd0, ({hi2, lo2} > {hi1, lo1})}, 32'd1);
      checkOutput("cnt_delta", {31'd0, (delta >= 32'd65540 && delta <= 32'd65560)}, 32'd1);
    end
`else
    readReg("cnt_lo_unm", 16'd5, rd);
    checkOutput("cnt_lo_unm_data", {16'd0, rd}, 32'h00000000);
    readReg("cnt_hi_unm", 16'd6, rd);
    checkOutput("cnt_hi_unm_data", {16'd0, rd}, 32'h00000000);
`endif

    // Hard reset in the accept cycle drops the response
    tick();
    address = 16'd0;
    rvalid  = 1'b1;
    rst     = 1'b1;
    tick();
    rvalid  = 1'b0;
    rst     = 1'b0;
    checkOutput("rstrd_rrvalid", {31'd0, rrvalid}, 32'd0);
    checkOutput("rstrd_rdata", {16'd0, rdata}, 32'd0);
    checkOutput("rstrd_led", {16'd0, led_out}, 32'h0000FFFF);
    tick();
    checkOutput("rstrd_rrvalid2", {31'd0, rrvalid}, 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
